// File: rtl/binary_div4.sv
// ============================================================================
// Module      : binary_div4
// Description : Sequential restoring unsigned divider, one quotient bit per
//               cycle (MSB first), with divide-by-zero flagging.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_div4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_CALC = 2'd1;
    localparam logic [1:0]       c_DONE = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_unused;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (divisor == '0) ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (r_cnt == c_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // One restoring step: the difference always fits WIDTH bits when taken.
    assign w_trial   = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge      = (w_trial >= {1'b0, r_divisor});
    assign w_diff    = w_trial - {1'b0, r_divisor};
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    assign w_unused  = w_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_dvd     <= dividend;
                r_divisor <= divisor;
                r_rem     <= '0;
                r_quo     <= '0;
                r_cnt     <= '0;
                r_dbz     <= 1'b0;
                if (divisor == '0) begin
                    r_quotient  <= '1;
                    r_remainder <= dividend;
                    r_dbz       <= 1'b1;
                end
            end else if (r_state == c_CALC) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_quotient  <= w_quo_nxt;
                    r_remainder <= w_rem_nxt;
                end
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state == c_CALC);
    assign done        = (r_state == c_DONE);

endmodule

`default_nettype wire

// File: tb/tb_binary_div4.sv
// ============================================================================
// Module      : tb_binary_div4
// Description : Directed and exhaustive checks for binary_div4 at WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_binary_div4;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int total = 0;
    int bad   = 0;

    binary_div4 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT idle; leaves it the same way.
    task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er,
                          input logic ez, input string name);
        int exp_lat;
        int lat;
        lat      = 0;
        exp_lat  = (b == 0) ? 1 : WIDTH + 1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (done) lat = k;
            else if (b != 0) check({name, " busy"}, {31'd0, busy}, 32'd1);
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check({name, " quotient"}, {28'd0, quotient}, {28'd0, eq});
        check({name, " remainder"}, {28'd0, remainder}, {28'd0, er});
        check({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
        @(posedge clk);
        #1;
        check({name, " done_pulse_width"}, {31'd0, done}, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int ndone;
        int first;
        int last;
        logic [3:0] cq;
        logic [3:0] cr;

        vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1,  1'b0};
        vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
        vecs[2] = '{4'd3,  4'd9,  4'd0,  4'd3,  1'b0};
        vecs[3] = '{4'd7,  4'd0,  4'd15, 4'd7,  1'b1};
        vecs[4] = '{4'd8,  4'd2,  4'd4,  4'd0,  1'b0};
        vecs[5] = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0};
        vecs[6] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
        vecs[7] = '{4'd0,  4'd0,  4'd15, 4'd0,  1'b1};
        vecs[8] = '{4'd15, 4'd0,  4'd15, 4'd15, 1'b1};
        vecs[9] = '{4'd1,  4'd15, 4'd0,  4'd1,  1'b0};

        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset quotient", {28'd0, quotient}, 32'd0);
        check("reset remainder", {28'd0, remainder}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk);
        #1;
        // Releasing reset with start asserted: the very next edge accepts.
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z,
                   $sformatf("vec%0d", i));

        // start pulsed during CALC must be ignored
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0; first = 0; cq = '0; cr = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2) begin start = 1'b1; dividend = 4'd9; divisor = 4'd3; end
            if (k == 3) start = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) begin first = k; cq = quotient; cr = remainder; end
            end
        end
        check("ignore_start done_count", ndone, 1);
        check("ignore_start latency", first, 5);
        check("ignore_start quotient", {28'd0, cq}, 32'd3);
        check("ignore_start remainder", {28'd0, cr}, 32'd1);
        @(posedge clk);
        #1;

        // reset in the second CALC cycle aborts the operation
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b0;
            if (k == 3) begin
                check("abort quotient", {28'd0, quotient}, 32'd0);
                check("abort remainder", {28'd0, remainder}, 32'd0);
                check("abort busy", {31'd0, busy}, 32'd0);
                check("abort div_by_zero", {31'd0, div_by_zero}, 32'd0);
                rst_n = 1'b1;
            end
            if (done) ndone++;
        end
        check("abort done_count", ndone, 0);
        @(posedge clk);
        #1;
        do_div(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, "after_abort");

        // start held high: back-to-back operations every WIDTH+2 cycles
        start = 1'b1; dividend = 4'd14; divisor = 4'd5;
        @(posedge clk);
        #1;
        ndone = 0; last = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                check("b2b busy_at_done", {31'd0, busy}, 32'd0);
                check("b2b quotient", {28'd0, quotient}, 32'd2);
                check("b2b remainder", {28'd0, remainder}, 32'd4);
                check("b2b spacing", k - last, (last == 0) ? 5 : 6);
                last = k;
                ndone++;
            end
            if (k == 30) start = 1'b0;
        end
        check("b2b done_count", ndone, 5);
        @(posedge clk);
        #1;

        // exhaustive sweep against the arithmetic reference
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    do_div(4'(a), 4'(b), 4'd15, 4'(a), 1'b1, $sformatf("sweep %0d/%0d", a, b));
                else
                    do_div(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, $sformatf("sweep %0d/%0d", a, b));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
